// File: rtl/dbg_stream_loader.sv
// Boot loader: holds the CPU in reset, turns a length-prefixed byte stream into
// little-endian words written through the debug memory port, then releases the CPU.
module dbg_stream_loader #(
    parameter int               DATA_W    = 32,
    parameter int               ADR_W     = 32,
    parameter logic [ADR_W-1:0] BASE_ADDR = ADR_W'(32'h20000),
    parameter logic [15:0]      MAX_WORDS = 16'hFFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                dbg_mem_op,
    output logic [ADR_W-1:0]    dbg_adr,
    output logic [DATA_W-1:0]   dbg_do,
    output logic [DATA_W/8-1:0] dbg_wren,
    input  logic                dbg_ack,
    input  logic                reload,
    output logic                cpu_n_reset,
    output logic                busy,
    output logic                err,
    output logic [15:0]         words_loaded
);

    localparam int               NB       = DATA_W / 8;
    localparam int               IDX_W    = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
    localparam logic [ADR_W-1:0] ADR_STEP = ADR_W'(NB);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        len_lo, len_lo_nxt;
    logic [15:0]       len, len_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [ADR_W-1:0]  adr_nxt;
    logic [DATA_W-1:0] do_nxt;
    logic [NB-1:0]     wren_nxt;
    logic              op_nxt, cpu_nxt, err_nxt;
    logic [15:0]       words_nxt;

    logic        take;
    logic [15:0] len_full;
    logic [15:0] words_inc;

    assign take      = in_valid & in_ready;
    assign len_full  = {in_data, len_lo};
    assign words_inc = words_loaded + 16'd1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) state <= S_LEN0;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LEN0:  if (take) state_nxt = S_LEN1;
            S_LEN1: begin
                if (take) begin
                    if (len_full == 16'd0)         state_nxt = S_DONE;
                    else if (len_full > MAX_WORDS) state_nxt = S_ERR;
                    else                           state_nxt = S_DATA;
                end
            end
            S_DATA:  if (take && idx == LAST_IDX) state_nxt = S_WRITE;
            S_WRITE: if (dbg_ack) state_nxt = (words_inc == len) ? S_DONE : S_DATA;
            S_DONE,
            S_ERR:   if (reload) state_nxt = S_LEN0;
            default: state_nxt = S_LEN0;
        endcase
    end

    // Output process: stream handshake decode plus next values of every
    // registered output, so each output flips on the same edge as the state.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        in_ready   = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);
        busy       = in_ready || (state == S_WRITE);
        len_lo_nxt = len_lo;
        len_nxt    = len;
        idx_nxt    = idx;
        adr_nxt    = dbg_adr;
        do_nxt     = dbg_do;
        op_nxt     = dbg_mem_op;
        cpu_nxt    = cpu_n_reset;
        err_nxt    = err;
        words_nxt  = words_loaded;
        unique case (state)
            S_LEN0: if (take) len_lo_nxt = in_data;
            S_LEN1: begin
                if (take) begin
                    len_nxt = len_full;
                    idx_nxt = '0;
                    adr_nxt = BASE_ADDR;
                    if (len_full == 16'd0)         cpu_nxt = 1'b1;
                    else if (len_full > MAX_WORDS) err_nxt = 1'b1;
                end
            end
            S_DATA: begin
                if (take) begin
                    for (int k = 0; k < NB; k++) begin
                        if (idx == IDX_W'(k)) do_nxt[8*k +: 8] = in_data;
                    end
                    if (idx == LAST_IDX) begin
                        idx_nxt = '0;
                        op_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (dbg_ack) begin
                    op_nxt    = 1'b0;
                    adr_nxt   = dbg_adr + ADR_STEP;
                    words_nxt = words_inc;
                    if (words_inc == len) cpu_nxt = 1'b1;
                end
            end
            S_DONE,
            S_ERR: begin
                if (reload) begin
                    cpu_nxt   = 1'b0;
                    err_nxt   = 1'b0;
                    words_nxt = 16'd0;
                    adr_nxt   = BASE_ADDR;
                end
            end
            default: ;
        endcase
        wren_nxt = {NB{op_nxt}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_lo       <= 8'd0;
            len          <= 16'd0;
            idx          <= '0;
            dbg_adr      <= BASE_ADDR;
            dbg_do       <= '0;
            dbg_mem_op   <= 1'b0;
            dbg_wren     <= '0;
            cpu_n_reset  <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            len_lo       <= len_lo_nxt;
            len          <= len_nxt;
            idx          <= idx_nxt;
            dbg_adr      <= adr_nxt;
            dbg_do       <= do_nxt;
            dbg_mem_op   <= op_nxt;
            dbg_wren     <= wren_nxt;
            cpu_n_reset  <= cpu_nxt;
            err          <= err_nxt;
            words_loaded <= words_nxt;
        end
    end

endmodule

// File: tb/tb_dbg_stream_loader.sv
// Bench for dbg_stream_loader: three builds (default, MAX_WORDS=4, 16-bit/8-bit
// address wrap) driven by directed images and checked against a write-list model.
module tb_dbg_stream_loader;

    localparam int N = 3;

    typedef struct {
        int          d;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  wren;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid [N];
    logic [7:0]  in_data  [N];
    logic        dbg_ack  [N];
    logic        reload   [N];
    logic        in_ready [N];
    logic        mem_op   [N];
    logic        cpu_n    [N];
    logic        busy     [N];
    logic        err      [N];
    logic [15:0] words    [N];
    logic [31:0] adr      [N];
    logic [31:0] dout     [N];
    logic [3:0]  wren     [N];

    logic [7:0]  adr_c;
    logic [15:0] do_c;
    logic [1:0]  wren_c;
    logic [3:0]  wren_a, wren_b;

    assign adr[2]  = {24'd0, adr_c};
    assign dout[2] = {16'd0, do_c};
    assign wren[2] = {2'b00, wren_c};
    assign wren[0] = wren_a;
    assign wren[1] = wren_b;

    dbg_stream_loader u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .dbg_mem_op(mem_op[0]), .dbg_adr(adr[0]), .dbg_do(dout[0]),
        .dbg_wren(wren_a), .dbg_ack(dbg_ack[0]), .reload(reload[0]), .cpu_n_reset(cpu_n[0]),
        .busy(busy[0]), .err(err[0]), .words_loaded(words[0])
    );

    dbg_stream_loader #(.MAX_WORDS(16'd4)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .dbg_mem_op(mem_op[1]), .dbg_adr(adr[1]), .dbg_do(dout[1]),
        .dbg_wren(wren_b), .dbg_ack(dbg_ack[1]), .reload(reload[1]), .cpu_n_reset(cpu_n[1]),
        .busy(busy[1]), .err(err[1]), .words_loaded(words[1])
    );

    dbg_stream_loader #(.DATA_W(16), .ADR_W(8), .BASE_ADDR(8'hFE)) u_dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_data(in_data[2]),
        .in_ready(in_ready[2]), .dbg_mem_op(mem_op[2]), .dbg_adr(adr_c), .dbg_do(do_c),
        .dbg_wren(wren_c), .dbg_ack(dbg_ack[2]), .reload(reload[2]), .cpu_n_reset(cpu_n[2]),
        .busy(busy[2]), .err(err[2]), .words_loaded(words[2])
    );

    int checks = 0;
    int errors = 0;

    wr_t         exp_q[$];
    wr_t         log_q[$];
    logic [31:0] img[$];
    logic [7:0]  bq[$];
    int          ack_delay [N];
    bit          ack_always[N];
    int          rises     [N];
    int          op_cycles [N];
    bit          mon_en = 1'b0;

    function automatic int nb_of(input int d);
        return (d == 2) ? 2 : 4;
    endfunction
    function automatic logic [31:0] base_of(input int d);
        return (d == 2) ? 32'hFE : 32'h20000;
    endfunction
    function automatic logic [31:0] amask(input int d);
        return (d == 2) ? 32'hFF : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] dmask(input int d);
        return (d == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [3:0] wmask(input int d);
        return (d == 2) ? 4'h3 : 4'hF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Memory responder: ack after ack_delay cycles of a pending write, or always high.
    initial begin
        int wc[N];
        for (int d = 0; d < N; d++) begin
            dbg_ack[d] = 1'b0;
            wc[d]      = 0;
        end
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < N; d++) begin
                if (ack_always[d]) begin
                    dbg_ack[d] = 1'b1;
                end else if (mem_op[d]) begin
                    wc[d]++;
                    dbg_ack[d] = (wc[d] >= ack_delay[d]);
                end else begin
                    wc[d]      = 0;
                    dbg_ack[d] = 1'b0;
                end
            end
        end
    end

    // Compare process: spec-level invariants each cycle, accepted writes vs model list.
    initial begin
        bit          prev_op [N];
        bit          prev_cpu[N];
        logic [31:0] prev_adr[N];
        logic [31:0] prev_do [N];
        wr_t         e, a;
        for (int d = 0; d < N; d++) begin
            prev_op[d] = 0; prev_cpu[d] = 0; prev_adr[d] = 0; prev_do[d] = 0;
        end
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int d = 0; d < N; d++) begin
                    check("in_ready_decode", {31'd0, in_ready[d]}, {31'd0, busy[d] & ~mem_op[d]});
                    check("wren_vs_op", {28'd0, wren[d]}, mem_op[d] ? {28'd0, wmask(d)} : 32'd0);
                    if (err[d]) check("err_holds_cpu", {30'd0, cpu_n[d], busy[d]}, 32'd0);
                    if (!busy[d]) check("idle_no_write", {31'd0, mem_op[d]}, 32'd0);
                    if (mem_op[d] && prev_op[d]) begin
                        check("adr_stable", adr[d], prev_adr[d]);
                        check("do_stable", dout[d], prev_do[d]);
                    end
                    if (mem_op[d]) op_cycles[d]++;
                    if (mem_op[d] && dbg_ack[d]) begin
                        a.d = d; a.adr = adr[d]; a.dat = dout[d]; a.wren = wren[d];
                        log_q.push_back(a);
                        if (exp_q.size() == 0) begin
                            check("unexpected_write", adr[d], 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            check("write_dut", d, e.d);
                            check("write_adr", adr[d], e.adr);
                            check("write_dat", dout[d], e.dat);
                            check("write_wren", {28'd0, wren[d]}, {28'd0, e.wren});
                        end
                    end
                    if (cpu_n[d] && !prev_cpu[d]) rises[d]++;
                    prev_op[d]  = mem_op[d];
                    prev_cpu[d] = cpu_n[d];
                    prev_adr[d] = adr[d];
                    prev_do[d]  = dout[d];
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        for (int d = 0; d < N; d++) begin
            check({tag, "_cpu"},   {31'd0, cpu_n[d]},  32'd0);
            check({tag, "_op"},    {31'd0, mem_op[d]}, 32'd0);
            check({tag, "_wren"},  {28'd0, wren[d]},   32'd0);
            check({tag, "_adr"},   adr[d],             base_of(d));
            check({tag, "_do"},    dout[d],            32'd0);
            check({tag, "_err"},   {31'd0, err[d]},    32'd0);
            check({tag, "_words"}, {16'd0, words[d]},  32'd0);
            check({tag, "_busy"},  {31'd0, busy[d]},   32'd1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int d = 0; d < N; d++) begin
            in_valid[d] = 1'b0;
            reload[d]   = 1'b0;
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_vals("rst_hi");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_after");
        mon_en = 1'b1;
        for (int d = 0; d < N; d++) begin
            rises[d]     = 0;
            op_cycles[d] = 0;
        end
    endtask

    task automatic send_bytes(input int d, input bit gaps);
        int cyc = 0;
        bit ph  = 1'b0;
        while (bq.size() > 0 && cyc < 4000) begin
            @(posedge clk); #1;
            ph          = ~ph;
            in_valid[d] = gaps ? ph : 1'b1;
            in_data[d]  = bq[0];
            @(negedge clk);
            if (in_valid[d] && in_ready[d]) void'(bq.pop_front());
            cyc++;
        end
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        check("stream_drained", bq.size(), 0);
    endtask

    // Model: header, LSB-first bytes and the expected write list from the image words.
    task automatic load_image(input int d, input bit gaps);
        logic [15:0] n;
        wr_t         e;
        n = 16'(img.size());
        bq.delete();
        bq.push_back(n[7:0]);
        bq.push_back(n[15:8]);
        for (int i = 0; i < img.size(); i++) begin
            for (int k = 0; k < nb_of(d); k++) bq.push_back(8'(img[i] >> (8 * k)));
            e.d    = d;
            e.adr  = (base_of(d) + 32'(i * nb_of(d))) & amask(d);
            e.dat  = img[i] & dmask(d);
            e.wren = wmask(d);
            exp_q.push_back(e);
        end
        send_bytes(d, gaps);
    endtask

    task automatic wait_end(input int d, output int cyc);
        bit reached = 1'b0;
        cyc = 0;
        while (!reached && cyc < 200) begin
            @(negedge clk);
            reached = (cpu_n[d] && !busy[d]) || err[d];
            if (!reached) cyc++;
        end
        check("end_reached", {31'd0, reached}, 32'd1);
    endtask

    task automatic pulse_reload(input int d);
        @(posedge clk); #1;
        reload[d] = 1'b1;
        @(posedge clk); #1;
        reload[d] = 1'b0;
        @(negedge clk);
        check("reload_err",   {31'd0, err[d]},   32'd0);
        check("reload_cpu",   {31'd0, cpu_n[d]}, 32'd0);
        check("reload_busy",  {31'd0, busy[d]},  32'd1);
        check("reload_words", {16'd0, words[d]}, 32'd0);
        check("reload_adr",   adr[d],            base_of(d));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        for (int d = 0; d < N; d++) begin
            in_valid[d] = 1'b0; in_data[d] = 8'h00; reload[d] = 1'b0;
            ack_delay[d] = 1; ack_always[d] = 1'b0; rises[d] = 0; op_cycles[d] = 0;
        end

        // Program load, ack two cycles into each write.
        do_reset();
        log_q.delete();
        ack_delay[0] = 2;
        img = '{32'h000107b7, 32'h0007a023, 32'h0000006f};
        load_image(0, 1'b0);
        wait_end(0, n);
        check("t1_words", {16'd0, words[0]}, 32'd3);
        check("t1_cpu", {31'd0, cpu_n[0]}, 32'd1);
        check("t1_busy", {31'd0, busy[0]}, 32'd0);
        check("t1_rises", rises[0], 1);
        check("t1_op_cycles", op_cycles[0], 6);
        check("t1_nwrites", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("t1_adr0", log_q[0].adr, 32'h20000);
            check("t1_dat0", log_q[0].dat, 32'h000107b7);
            check("t1_wren0", {28'd0, log_q[0].wren}, 32'hF);
            check("t1_adr1", log_q[1].adr, 32'h20004);
            check("t1_adr2", log_q[2].adr, 32'h20008);
            check("t1_dat2", log_q[2].dat, 32'h0000006f);
        end

        // Zero-length header goes straight to DONE with no write.
        do_reset();
        log_q.delete();
        bq = '{8'h00, 8'h00};
        send_bytes(0, 1'b0);
        wait_end(0, n);
        check("t2_latency_ok", {31'd0, n < 2}, 32'd1);
        check("t2_cpu", {31'd0, cpu_n[0]}, 32'd1);
        check("t2_no_op", op_cycles[0], 0);
        check("t2_nwrites", log_q.size(), 0);

        // Length error on the MAX_WORDS=4 build, then reload and recover.
        do_reset();
        log_q.delete();
        bq = '{8'h05, 8'h00};
        send_bytes(1, 1'b0);
        wait_end(1, n);
        check("t3_err", {31'd0, err[1]}, 32'd1);
        check("t3_cpu", {31'd0, cpu_n[1]}, 32'd0);
        check("t3_ready", {31'd0, in_ready[1]}, 32'd0);
        @(posedge clk); #1;
        in_valid[1] = 1'b1;
        in_data[1]  = 8'hAA;
        repeat (3) @(negedge clk);
        check("t3_still_err", {31'd0, err[1]}, 32'd1);
        check("t3_ready_err", {31'd0, in_ready[1]}, 32'd0);
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        pulse_reload(1);
        img = '{32'hdeadbeef};
        load_image(1, 1'b0);
        wait_end(1, n);
        check("t3_err_clear", {31'd0, err[1]}, 32'd0);
        check("t3_cpu_up", {31'd0, cpu_n[1]}, 32'd1);
        check("t3_nwrites", log_q.size(), 1);
        if (log_q.size() == 1) check("t3_adr0", log_q[0].adr, 32'h20000);
        // A header exactly at MAX_WORDS is accepted.
        pulse_reload(1);
        img = '{32'h1, 32'h2, 32'h3, 32'h4};
        load_image(1, 1'b0);
        wait_end(1, n);
        check("t3_max_err", {31'd0, err[1]}, 32'd0);
        check("t3_max_words", {16'd0, words[1]}, 32'd4);

        // Ack held off for 10 cycles per write while in_valid toggles.
        do_reset();
        log_q.delete();
        ack_delay[0] = 11;
        img = '{32'h11223344, 32'ha5a55a5a};
        load_image(0, 1'b1);
        wait_end(0, n);
        check("t4_words", {16'd0, words[0]}, 32'd2);
        check("t4_op_cycles", op_cycles[0], 22);
        check("t4_nwrites", log_q.size(), 2);

        // 16-bit words with an 8-bit address wrapping from FE to 00.
        do_reset();
        log_q.delete();
        img = '{32'h1234, 32'habcd};
        load_image(2, 1'b0);
        wait_end(2, n);
        check("t5_words", {16'd0, words[2]}, 32'd2);
        check("t5_nwrites", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("t5_adr0", log_q[0].adr, 32'hFE);
            check("t5_dat0", log_q[0].dat, 32'h1234);
            check("t5_wren0", {28'd0, log_q[0].wren}, 32'h3);
            check("t5_adr1", log_q[1].adr, 32'h00);
            check("t5_dat1", log_q[1].dat, 32'habcd);
        end

        // Reset after two bytes of the first word, then a clean load with ack always high.
        do_reset();
        log_q.delete();
        ack_delay[0] = 1;
        bq = '{8'h02, 8'h00, 8'h11, 8'h22};
        send_bytes(0, 1'b0);
        do_reset();
        check("t6_no_write", log_q.size(), 0);
        ack_always[0] = 1'b1;
        img = '{32'hcafef00d, 32'h01234567};
        load_image(0, 1'b0);
        wait_end(0, n);
        check("t6_words", {16'd0, words[0]}, 32'd2);
        check("t6_op_cycles", op_cycles[0], 2);
        check("t6_nwrites", log_q.size(), 2);
        if (log_q.size() == 2) check("t6_dat0", log_q[0].dat, 32'hcafef00d);
        ack_always[0] = 1'b0;

        check("model_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
